bus_generator_n_arbiter: RTL and testbench

Shared-bus generator and arbiter connecting `drvrs` device FIFOs. It grants one pending device at a time using round-robin order. It pops that device's head packet and decodes the destination ID in the packet's top 8 bits. It then pushes the packet into the destination device, or into every other device when the ID is the broadcast ID. It sits between the per-device FIFO drivers and acts as the system interconnect.

---
 rtl/bus_generator_n_arbiter_pkg.sv | 32 +++
 rtl/bus_generator_n_arbiter_if.sv | 39 +++
 rtl/bus_generator_n_arbiter_rr_arbiter.sv | 49 ++++
 rtl/bus_generator_n_arbiter.sv | 138 +++++++++++++
 tb/tb_bus_generator_n_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus_generator_n_arbiter_pkg.sv
// Shared types, constants and packet helpers for the bus generator / arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: ID_W (destination-ID width), BROADCAST (default all-but-source ID),
// PKT_MAX_W (widest packet the ID helper accepts), state_e (per-bus FSM
// states) and pkt_id() (pulls the destination ID out of a packet's top byte).
package bus_gen_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST = 8'hFF;

  // Upper bound on pckg_sz for pkt_id(); callers zero-extend into this width.
  localparam int PKT_MAX_W = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_e;

  // Destination ID lives in the top ID_W bits of a pkt_w-wide packet.
  // The packet arrives zero-extended to PKT_MAX_W so one function serves
  // every packet width.
  function automatic logic [ID_W-1:0] pkt_id(input logic [PKT_MAX_W-1:0] pkt,
                                             input int pkt_w);
    logic [PKT_MAX_W-1:0] sh;
    sh = pkt >> (pkt_w - ID_W);
    return sh[ID_W-1:0];
  endfunction

endpackage

// File: rtl/bus_generator_n_arbiter_if.sv
// Bundle of the device-FIFO side signals of the shared-bus arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; devices hold pndng/D_pop until popped.
//
// pndng  : per bus, per device FIFO non-empty
// D_pop  : per bus, per device FIFO head packet (valid while pndng)
// pop    : per bus, per device one-cycle pop strobe
// push   : per bus, per device one-cycle push strobe
// D_push : per bus packet shared by all devices
// master = arbiter side, slave = device side.
interface bus_generator_n_arbiter_if #(
  parameter int bits    = 1,
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);

  logic [bits-1:0][drvrs-1:0]              pndng;
  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop;
  logic [bits-1:0][drvrs-1:0]              pop;
  logic [bits-1:0][drvrs-1:0]              push;
  logic [bits-1:0][pckg_sz-1:0]            D_push;

  modport master (
    input  pndng,
    input  D_pop,
    output pop,
    output push,
    output D_push
  );

  modport slave (
    output pndng,
    output D_pop,
    input  pop,
    input  push,
    input  D_push
  );

endinterface

// File: rtl/bus_generator_n_arbiter_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr_i, wrapping at drvrs-1.
// Latency: purely combinational.
// Backpressure: none; grant follows req_i/ptr_i in the same cycle.
//
// req_i : request vector, one bit per device
// ptr_i : round-robin pointer (device with highest priority), < drvrs
// gnt_o : one-hot grant (all zero when nothing requests)
// idx_o : index of the granted device
// vld_o : some device is granted
module rr_arbiter
  import bus_gen_pkg::*;
#(
  parameter int drvrs = 4
) (
  input  logic [drvrs-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [drvrs-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             vld_o
);

  // Each requester's distance from the pointer, going upward with wrap;
  // the smallest distance wins. Only constant indices are used, so this
  // flattens into plain compare/select logic.
  always_comb begin
    int best;
    int d;
    best  = drvrs;
    d     = 0;
    idx_o = '0;
    for (int j = 0; j < drvrs; j++) begin
      d = j - int'(ptr_i);
      if (d < 0) d = d + drvrs;
      if (req_i[j] && (d < best)) begin
        best  = d;
        idx_o = ID_W'(j);
      end
    end
    vld_o = (best < drvrs);
  end

  always_comb begin
    gnt_o = '0;
    for (int j = 0; j < drvrs; j++) begin
      gnt_o[j] = vld_o && (idx_o == ID_W'(j));
    end
  end

endmodule

// File: rtl/bus_generator_n_arbiter.sv
// Shared-bus generator/arbiter: pops one device packet per bus and routes it
// to its destination device (or all others on broadcast).
// Latency: pndng seen at edge N -> pop during N+1 -> push/D_push during N+2.
// Backpressure: none; one packet per 3 cycles per bus, destinations always accept.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : master side of bus_generator_n_arbiter_if (pndng, D_pop in;
//           pop, push, D_push out), bits independent buses of drvrs devices
// Packet: [pckg_sz-1 -: 8] destination ID, rest is untouched payload.
module bus_generator_n_arbiter
  import bus_gen_pkg::*;
#(
  parameter int              bits      = 1,
  parameter int              drvrs     = 4,     // 2..255
  parameter int              pckg_sz   = 16,    // >= 9
  parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
  input  logic                        clk,
  input  logic                        reset,
  bus_generator_n_arbiter_if.master   bus
);

  for (genvar b = 0; b < bits; b++) begin : g_bus

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [ID_W-1:0]     src_q, src_d;
    logic [drvrs-1:0]    pop_q, pop_d;
    logic [drvrs-1:0]    push_q, push_d;
    logic [pckg_sz-1:0]  dat_q, dat_d;

    logic [drvrs-1:0]    gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_vld;
    logic [pckg_sz-1:0]  head;
    logic [ID_W-1:0]     id;

    rr_arbiter #(
      .drvrs (drvrs)
    ) u_arb (
      .req_i (bus.pndng[b]),
      .ptr_i (rr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .vld_o (gnt_vld)
    );

    // While in POP, pop_q is still the one-hot grant from the IDLE decision,
    // so it doubles as the select for the popped device's head packet.
    always_comb begin
      head = '0;
      for (int j = 0; j < drvrs; j++) begin
        if (pop_q[j]) head = head | bus.D_pop[b][j];
      end
    end

    assign id = pkt_id(PKT_MAX_W'(head), pckg_sz);

    // State register
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        rr_q    <= '0;
        src_q   <= '0;
        pop_q   <= '0;
        push_q  <= '0;
        dat_q   <= '0;
      end else begin
        state_q <= state_d;
        rr_q    <= rr_d;
        src_q   <= src_d;
        pop_q   <= pop_d;
        push_q  <= push_d;
        dat_q   <= dat_d;
      end
    end

    // Next state
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        IDLE:    if (gnt_vld) state_d = POP;
        POP:     state_d = PUSH;
        PUSH:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are computed one state ahead and registered, so pop appears
    // in the POP cycle and push/D_push in the PUSH cycle with no input-to-
    // output combinational path.
    always_comb begin
      pop_d  = '0;
      push_d = '0;
      dat_d  = dat_q;
      src_d  = src_q;
      rr_d   = rr_q;
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            pop_d = gnt;
            src_d = gnt_idx;
          end
        end
        POP: begin
          dat_d = head;
          // Broadcast is checked first so it wins even if it aliases a
          // device index. An ID equal to the source or beyond the last
          // device matches no push bit: the packet is dropped.
          for (int j = 0; j < drvrs; j++) begin
            if (id == broadcast) begin
              push_d[j] = (ID_W'(j) != src_q);
            end else begin
              push_d[j] = (id == ID_W'(j)) && (id != src_q);
            end
          end
        end
        PUSH: begin
          rr_d = (src_q == ID_W'(drvrs - 1)) ? '0 : src_q + ID_W'(1);
        end
        default: ;
      endcase
    end

    assign bus.pop[b]    = pop_q;
    assign bus.push[b]   = push_q;
    assign bus.D_push[b] = dat_q;

    a_no_pop_push: assert property (@(posedge clk) disable iff (reset)
      !((|pop_q) && (|push_q)));
    a_pop_onehot: assert property (@(posedge clk) disable iff (reset)
      $onehot0(pop_q));

  end

endmodule

// File: tb/tb_bus_generator_n_arbiter.sv
module tb_bus_generator_n_arbiter;

  localparam int N = 8;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  bus_generator_n_arbiter_if #(.bits(1), .drvrs(N), .pckg_sz(W)) bus_if ();

  bus_generator_n_arbiter #(
    .bits      (1),
    .drvrs     (N),
    .pckg_sz   (W),
    .broadcast (8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // dq: device FIFOs as the DUT sees them; mq: the reference model's view.
  logic [W-1:0] dq [N][$];
  logic [W-1:0] mq [N][$];
  logic [N-1:0] pop_seen = '0;

  // Reference model: transaction schedule.
  int           rr      = 0;
  int           nd      = 0;
  int           pop_c   = -1;
  int           push_c  = -1;
  int           dat_c   = -1;
  logic [N-1:0] pop_v   = '0;
  logic [N-1:0] push_v  = '0;
  logic [W-1:0] dat_v   = '0;
  logic [W-1:0] dat_cur = '0;

  // Scenario controls
  int rst_cycles = 0;
  bit rst_midop  = 0;
  bit rnd_on     = 0;
  bit rec_on     = 0;
  int rec_idx[$];
  int rec_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [N-1:0] route_mask(input logic [W-1:0] pkt, input int src);
    logic [7:0]   idb;
    logic [N-1:0] m;
    idb = pkt[W-1 -: 8];
    m   = '0;
    if (idb == 8'hFF) begin
      m      = '1;
      m[src] = 1'b0;
    end else if ((int'(idb) < N) && (int'(idb) != src)) begin
      m[idb[2:0]] = 1'b1;
    end
    return m;
  endfunction

  task automatic enq(input int dev, input logic [W-1:0] pkt);
    dq[dev].push_back(pkt);
    mq[dev].push_back(pkt);
  endtask

  function automatic logic [W-1:0] rand_pkt();
    int r;
    logic [7:0] idb;
    r = $urandom_range(0, 9);
    if (r < 6)      idb = 8'($urandom_range(0, N - 1));
    else if (r < 8) idb = 8'hFF;
    else            idb = 8'($urandom_range(N, 254));
    return {idb, 8'($urandom)};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus_if.pndng[0][i] = (dq[i].size() > 0);
      bus_if.D_pop[0][i] = (dq[i].size() > 0) ? dq[i][0] : 16'hDEAD;
    end
  endtask

  task automatic step();
    logic [N-1:0] e_pop, e_push;
    bit found;
    int w;
    @(posedge clk);
    #1;
    cyc++;
    // Device FIFOs retire the head that the DUT popped at this edge.
    for (int i = 0; i < N; i++) begin
      if (pop_seen[i] && dq[i].size() > 0) void'(dq[i].pop_front());
    end
    if (rnd_on) begin
      for (int i = 0; i < N; i++) begin
        if (dq[i].size() < 3 && $urandom_range(0, 99) < 15) enq(i, rand_pkt());
      end
    end
    reset = 1'b0;
    if (rst_cycles > 0) begin
      reset = 1'b1;
      rst_cycles--;
    end
    if (rst_midop && push_c == cyc) begin
      reset     = 1'b1;
      rst_midop = 0;
      enq(3, 16'h0077);
      enq(0, 16'h03A1);
    end
    drive();

    @(negedge clk);
    if (dat_c == cyc) dat_cur = dat_v;
    e_pop  = (pop_c == cyc)  ? pop_v  : '0;
    e_push = (push_c == cyc) ? push_v : '0;
    check("pop",    32'(bus_if.pop[0]),    32'(e_pop));
    check("push",   32'(bus_if.push[0]),   32'(e_push));
    check("D_push", 32'(bus_if.D_push[0]), 32'(dat_cur));

    if (rec_on && (bus_if.pop[0] != '0)) begin
      for (int j = 0; j < N; j++) if (bus_if.pop[0][j]) rec_idx.push_back(j);
      rec_cyc.push_back(cyc);
    end

    // Model: what happens at the coming edge given this cycle's inputs.
    if (reset) begin
      rr     = 0;
      pop_c  = -1;
      push_c = -1;
      dat_c  = cyc + 1;
      dat_v  = '0;
      nd     = cyc + 1;
    end else if (cyc >= nd) begin
      found = 0;
      w     = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && mq[(rr + k) % N].size() > 0) begin
          found = 1;
          w     = (rr + k) % N;
        end
      end
      if (found) begin
        dat_v    = mq[w].pop_front();
        pop_v    = '0;
        pop_v[w] = 1'b1;
        push_v   = route_mask(dat_v, w);
        pop_c    = cyc + 1;
        push_c   = cyc + 2;
        dat_c    = cyc + 2;
        rr       = (w + 1) % N;
        nd       = cyc + 3;
      end
    end
    pop_seen = bus_if.pop[0];
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus_if.pndng = '0;
    bus_if.D_pop = '0;
    rst_cycles = 1;
    run(3);

    // Unicast: device 2 -> device 5
    enq(2, 16'h05AB);
    run(6);

    // Broadcast from device 3
    enq(3, 16'hFF12);
    run(6);

    // Drops: ID beyond last device, then ID equal to source
    enq(1, 16'h0900);
    enq(1, 16'h01CD);
    run(10);

    // Reset during the PUSH cycle of a unicast; devices 0 and 3 then pending
    enq(5, 16'h0155);
    rst_midop = 1;
    run(12);

    // Round robin: fresh pointer, every device continuously pending
    rst_cycles = 1;
    run(2);
    for (int i = 0; i < N; i++) begin
      for (int r = 0; r < 3; r++) enq(i, {8'((i + 1) % N), 8'(r * 16 + i)});
    end
    rec_on = 1;
    run(80);
    rec_on = 0;
    if (rec_idx.size() < 9) begin
      check("rr_pop_count", 32'(rec_idx.size()), 32'(9));
    end else begin
      for (int k = 0; k < 9; k++) begin
        check("rr_order", 32'(rec_idx[k]), 32'(k % N));
        if (k > 0) check("rr_gap", 32'(rec_cyc[k] - rec_cyc[k-1]), 32'(3));
      end
    end

    // Random traffic
    rnd_on = 1;
    run(1500);
    rnd_on = 0;
    run(120);

    // Long idle: strobes stay low, D_push holds
    run(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
